// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_ctrl_if : write bus and display pins of seg7_scan_ctrl |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface seg7_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic              wr_en;
  logic [4*NDIG-1:0] wr_data;
  logic [NDIG-1:0]   wr_blank;
  logic [2:0]        bright;
  logic [6:0]        seg7;
  logic [NDIG-1:0]   digit_n;
  logic              frame_tick;
  logic              upd_pend;

  modport master (
    output wr_en, wr_data, wr_blank, bright,
    input  seg7, digit_n, frame_tick, upd_pend
  );

  modport slave (
    input  wr_en, wr_data, wr_blank, bright,
    output seg7, digit_n, frame_tick, upd_pend
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_ctrl : double-buffered 7-seg scan, optional SEG7_DIM_EN |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seg7_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int ON_CYCLES    = 12000,
  parameter int BLANK_CYCLES = 480
) (
  input  wire logic       clk,
  input  wire logic       res,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0]      c_ST_BLANK   = 1'b0;
  localparam logic [0:0]      c_ST_ON      = 1'b1;
  localparam logic [15:0]     c_ON_LAST    = 16'(ON_CYCLES - 1);
  localparam logic [15:0]     c_BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]   c_IDX_LAST   = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] c_DIG_ONE    = NDIG'(1);

  logic [0:0]        r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic              r_first;
  logic [4*NDIG-1:0] r_shd_data, r_act_data;
  logic [NDIG-1:0]   r_shd_blank, r_act_blank;
  logic              r_frame_tick, r_upd_pend;
  logic [6:0]        r_seg7, w_seg7_nxt;
  logic [NDIG-1:0]   r_digit_n, w_digit_n_nxt;
  logic              w_wrap, w_boundary, w_dim_ok, w_lit;
  logic [4*NDIG-1:0] w_shift;
  logic [3:0]        w_nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= c_ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_ST_BLANK: begin
        if (r_cnt == c_BLANK_LAST) begin
          w_state_nxt = c_ST_ON;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_ON: begin
        if (r_cnt == c_ON_LAST) begin
          w_state_nxt = c_ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
    endcase
  end

  // Frame boundary: leaving the last digit's ON slot, or the first cycle out of reset.
  assign w_wrap     = (r_state == c_ST_ON) && (r_cnt == c_ON_LAST) && (r_idx == c_IDX_LAST);
  assign w_boundary = r_first | w_wrap;

  always_ff @(posedge clk) begin
    if (res) begin
      r_first      <= 1'b1;
      r_shd_data   <= '0;
      r_shd_blank  <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '0;
      r_frame_tick <= 1'b0;
      r_upd_pend   <= 1'b0;
    end else begin
      r_first      <= 1'b0;
      r_frame_tick <= w_boundary;
      if (bus.wr_en) begin
        r_shd_data  <= bus.wr_data;
        r_shd_blank <= bus.wr_blank;
      end
      // A write landing on the boundary bypasses the shadow so it is never left pending.
      if (w_boundary) begin
        r_act_data  <= bus.wr_en ? bus.wr_data  : r_shd_data;
        r_act_blank <= bus.wr_en ? bus.wr_blank : r_shd_blank;
        r_upd_pend  <= 1'b0;
      end else if (bus.wr_en) begin
        r_upd_pend  <= 1'b1;
      end
    end
  end

`ifdef SEG7_DIM_EN
  localparam logic [18:0] c_DIM_STEP = 19'(ON_CYCLES >> 3);
  logic [2:0] r_bright;

  always_ff @(posedge clk) begin
    if (res) begin
      r_bright <= '0;
    end else if (w_boundary) begin
      r_bright <= bus.bright;
    end
  end

  assign w_dim_ok = ({3'b000, r_cnt} < (c_DIM_STEP * (19'(r_bright) + 19'd1)));
`else
  logic w_unused_bright;
  assign w_unused_bright = ^bus.bright;
  assign w_dim_ok        = 1'b1;
`endif

  assign w_shift = r_act_data >> {r_idx, 2'b00};
  assign w_nib   = w_shift[3:0];

  always_comb begin
    w_lit         = (r_state == c_ST_ON) && !r_act_blank[r_idx] && w_dim_ok;
    w_seg7_nxt    = 7'h7F;
    w_digit_n_nxt = '1;
    if (w_lit) begin
      w_seg7_nxt    = ~hex7(w_nib);
      w_digit_n_nxt = ~(c_DIG_ONE << r_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_seg7    <= 7'h7F;
      r_digit_n <= '1;
    end else begin
      r_seg7    <= w_seg7_nxt;
      r_digit_n <= w_digit_n_nxt;
    end
  end

  assign bus.seg7       = r_seg7;
  assign bus.digit_n    = r_digit_n;
  assign bus.frame_tick = r_frame_tick;
  assign bus.upd_pend   = r_upd_pend;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seg7_scan_ctrl : directed self-checking bench, NDIG=4 ON=8 B=2 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_seg7_scan_ctrl;

  localparam int c_NDIG  = 4;
  localparam int c_ON    = 8;
  localparam int c_BLANK = 2;
  localparam int c_SLOT  = c_ON + c_BLANK;
  localparam int c_FRAME = c_NDIG * c_SLOT;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic        t_wr_en    = 1'b0;
  logic [15:0] t_wr_data  = 16'h0000;
  logic [3:0]  t_wr_blank = 4'h0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference state: shadow/active image and pending flag as seen from the pins
  logic [15:0] sh_img, act_img;
  logic [3:0]  sh_blk, act_blk;
  logic        m_pend;

  seg7_scan_ctrl_if #(.NDIG(c_NDIG)) bus ();

  assign bus.wr_en    = t_wr_en;
  assign bus.wr_data  = t_wr_data;
  assign bus.wr_blank = t_wr_blank;
  assign bus.bright   = 3'd7;

  seg7_scan_ctrl #(
    .NDIG        (c_NDIG),
    .ON_CYCLES   (c_ON),
    .BLANK_CYCLES(c_BLANK)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    sh_img  = 16'h0000;
    sh_blk  = 4'h0;
    act_img = 16'h0000;
    act_blk = 4'h0;
    m_pend  = 1'b0;
    cyc     = 0;
  endtask

  // Advance n cycles; output at cycle e reflects the scan position of cycle e-1.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int e, t, d;
      logic bnd, lit;
      logic [6:0] es;
      logic [3:0] ed;
      e   = cyc + 1;
      t   = e - 1;
      d   = (t % c_FRAME) / c_SLOT;
      lit = ((t % c_SLOT) >= c_BLANK) && !act_blk[d];
      es  = lit ? ~hex7(act_img[4*d +: 4]) : 7'h7F;
      ed  = lit ? ~(4'b0001 << d) : 4'hF;
      bnd = (e == 1) || (e % c_FRAME == 0);
      if (t_wr_en) begin
        sh_img = t_wr_data;
        sh_blk = t_wr_blank;
      end
      if (bnd) begin
        act_img = sh_img;
        act_blk = sh_blk;
        m_pend  = 1'b0;
      end else if (t_wr_en) begin
        m_pend = 1'b1;
      end
      @(negedge clk);
      cyc = e;
      chk("seg7",       {25'd0, bus.seg7},    {25'd0, es});
      chk("digit_n",    {28'd0, bus.digit_n}, {28'd0, ed});
      chk("frame_tick", {31'd0, bus.frame_tick}, {31'd0, bnd});
      chk("upd_pend",   {31'd0, bus.upd_pend},   {31'd0, m_pend});
    end
  endtask

  task automatic do_write(input logic [15:0] data, input logic [3:0] blank);
    t_wr_en    = 1'b1;
    t_wr_data  = data;
    t_wr_blank = blank;
    run_cycles(1);
    t_wr_en    = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_seg7",       {25'd0, bus.seg7},    32'h7F);
    chk("rst_digit_n",    {28'd0, bus.digit_n}, 32'hF);
    chk("rst_frame_tick", {31'd0, bus.frame_tick}, 32'h0);
    chk("rst_upd_pend",   {31'd0, bus.upd_pend},   32'h0);
    res = 1'b0;

    run_cycles(3);
    chk("spot_c3_seg7",    {25'd0, bus.seg7},    32'h01);
    chk("spot_c3_digit_n", {28'd0, bus.digit_n}, 32'hE);
    run_cycles(37);

    // Mid-frame write: held in shadow until the next boundary
    run_cycles(15);
    do_write(16'h3A7F, 4'h0);
    chk("spot_pend_set", {31'd0, bus.upd_pend}, 32'h1);
    run_cycles(27);
    chk("spot_F_seg7",    {25'd0, bus.seg7},    32'h38);
    chk("spot_F_digit_n", {28'd0, bus.digit_n}, 32'hE);
    run_cycles(36);

    // Write on the boundary edge: bypassed, pend never rises
    do_write(16'h1234, 4'h0);
    chk("spot_bypass_pend", {31'd0, bus.upd_pend}, 32'h0);
    run_cycles(3);
    chk("spot_4_seg7", {25'd0, bus.seg7}, 32'h4C);
    run_cycles(17);

    // Blank mask on digits 1 and 3
    do_write(16'h1234, 4'b1010);
    run_cycles(32);
    chk("spot_blank_seg7",    {25'd0, bus.seg7},    32'h7F);
    chk("spot_blank_digit_n", {28'd0, bus.digit_n}, 32'hF);
    run_cycles(27);

    // Pending write then reset while digit 2 is on
    do_write(16'hBEEF, 4'h0);
    run_cycles(24);
    chk("spot_d2_seg7",    {25'd0, bus.seg7},    32'h12);
    chk("spot_d2_digit_n", {28'd0, bus.digit_n}, 32'hB);
    res = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg7",       {25'd0, bus.seg7},    32'h7F);
    chk("mid_rst_digit_n",    {28'd0, bus.digit_n}, 32'hF);
    chk("mid_rst_upd_pend",   {31'd0, bus.upd_pend},   32'h0);
    chk("mid_rst_frame_tick", {31'd0, bus.frame_tick}, 32'h0);
    res = 1'b0;
    model_reset();
    run_cycles(2 * c_FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
